// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to the
// instruction memory and buffers returned instructions, each tagged with its
// PC, in a small prefetch FIFO. A downstream redirect flushes the queue and
// restarts fetch at the redirect address.
module fetch_queue #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Control state
    logic [ADDR_W-1:0] fetch_pc_q,   fetch_pc_d;
    logic              pending_q,    pending_d;
    logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
    logic [PTR_W-1:0]  head_q,       head_d;
    logic [PTR_W-1:0]  tail_q,       tail_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    // FIFO storage (data only, never reset)
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

    logic [CNT_W-1:0] occupancy;
    logic             issue;
    logic             push;
    logic             pop;

    // Outputs are driven from registered state only; instr_ready never reaches them.
    assign instr_valid = (count_q != '0) && !rst;
    assign instr       = instr_mem_q[head_q];
    assign instr_pc    = pc_mem_q[head_q];
    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;

    // Issue/push/pop decisions; the in-flight request reserves its slot up front.
    always_comb begin
        occupancy = count_q + CNT_W'(pending_q);
        issue     = !rst && !redirect && (occupancy < DEPTH_CNT);
        push      = pending_q && !redirect && !rst;
        pop       = instr_valid && instr_ready && !redirect;
    end

    // Next-state for PC, in-flight tracking and FIFO pointers; redirect flushes everything.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            pending_d  = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            pending_d = issue;
            if (issue) begin
                pending_pc_d = fetch_pc_q;
                fetch_pc_d   = fetch_pc_q + ADDR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset; reset drops the queue and any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            pending_q  <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pending_q  <= pending_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // PC of the outstanding request; only meaningful while pending_q is set.
    always_ff @(posedge clk) begin
        pending_pc_q <= pending_pc_d;
    end

    // Capture the memory response together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[tail_q] <= imem_rdata;
            pc_mem_q[tail_q]    <= pending_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, back-pressure, redirect, wrap-around,
// simultaneous redirect/reset, and a random-ready scoreboard run.
module tb_fetch_queue;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 19;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready = 1'b0;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_pc = '0;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, instr = {7'b0, addr}; junk when not requested.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {7'b0, imem_addr};
        else          imem_rdata <= 19'h5A5A5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, check reset outputs, release: caller is then in cycle 0.
    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect = 1'b0;
        instr_ready = rdy;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int nreq;
        int issued;
        int popped;
        logic [ADDR_W-1:0] exp_pc;

        // Reset and streaming
        do_reset(1'b1);
        for (int c = 0; c < 12; c++) begin
            chk("s_req", 32'(imem_req), 32'd1);
            chk("s_addr", 32'(imem_addr), 32'(c));
            if (c < 2) begin
                chk("s_valid0", 32'(instr_valid), 32'd0);
            end else begin
                chk("s_valid", 32'(instr_valid), 32'd1);
                chk("s_pc", 32'(instr_pc), 32'(c - 2));
                chk("s_instr", 32'(instr), 32'(c - 2));
            end
            tick();
        end

        // Redirect from steady state (queue non-empty, response pending)
        chk("r_valid_pre", 32'(instr_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 12'h123;
        #1;
        chk("r_req_r", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("r_req_r1", 32'(imem_req), 32'd1);
        chk("r_addr_r1", 32'(imem_addr), 32'h123);
        chk("r_valid_r1", 32'(instr_valid), 32'd0);
        tick();
        chk("r_valid_r2", 32'(instr_valid), 32'd0);
        tick();
        chk("r_valid_r3", 32'(instr_valid), 32'd1);
        chk("r_pc_r3", 32'(instr_pc), 32'h123);
        chk("r_instr_r3", 32'(instr), 32'h123);
        tick();
        chk("r_pc_r4", 32'(instr_pc), 32'h124);

        // Wrap-around of the fetch PC
        redirect = 1'b1;
        redirect_pc = 12'hFFE;
        #1;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        exp_pc = 12'hFFE;
        for (int k = 0; k < 4; k++) begin
            chk("w_valid", 32'(instr_valid), 32'd1);
            chk("w_pc", 32'(instr_pc), 32'(exp_pc));
            chk("w_instr", 32'(instr), 32'(exp_pc));
            exp_pc = exp_pc + 12'd1;
            tick();
        end

        // Back-pressure: exactly DEPTH requests, then in-order drain
        do_reset(1'b0);
        nreq = 0;
        for (int c = 0; c < 10; c++) begin
            if (imem_req) nreq++;
            tick();
        end
        chk("bp_nreq", 32'(nreq), 32'(DEPTH));
        chk("bp_req_full", 32'(imem_req), 32'd0);
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_head", 32'(instr_pc), 32'd0);
        instr_ready = 1'b1;
        #1;
        chk("bp_req_pop", 32'(imem_req), 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("bp_dvalid", 32'(instr_valid), 32'd1);
            chk("bp_dpc", 32'(instr_pc), 32'(k));
            if (k == 1) begin
                chk("bp_req_after", 32'(imem_req), 32'd1);
                chk("bp_addr_after", 32'(imem_addr), 32'd4);
            end
            tick();
        end

        // Redirect together with a handshake while full, then reset with a response in flight
        do_reset(1'b0);
        for (int c = 0; c < 8; c++) tick();
        chk("sim_valid_full", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 12'h040;
        #1;
        chk("sim_req_r", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("sim_valid_r1", 32'(instr_valid), 32'd0);
        chk("sim_addr_r1", 32'(imem_addr), 32'h040);
        tick();
        chk("sim_valid_r2", 32'(instr_valid), 32'd0);
        tick();
        chk("sim_valid_r3", 32'(instr_valid), 32'd1);
        chk("sim_pc_r3", 32'(instr_pc), 32'h040);
        tick();
        chk("sim_pc_r4", 32'(instr_pc), 32'h041);
        rst = 1'b1;
        #1;
        chk("sim_rst_req", 32'(imem_req), 32'd0);
        chk("sim_rst_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("sim_rst_valid2", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("sim_c0_req", 32'(imem_req), 32'd1);
        chk("sim_c0_addr", 32'(imem_addr), 32'd0);
        tick();
        chk("sim_c1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("sim_c2_valid", 32'(instr_valid), 32'd1);
        chk("sim_c2_pc", 32'(instr_pc), 32'd0);

        // Random ready with a scoreboard
        do_reset(1'b0);
        issued = 0;
        popped = 0;
        exp_pc = '0;
        for (int c = 0; c < 1000; c++) begin
            instr_ready = 1'($urandom_range(0, 1));
            #1;
            if (imem_req) begin
                chk("rnd_req_room", 32'((issued - popped) < DEPTH), 32'd1);
                chk("rnd_req_addr", 32'(imem_addr), 32'(ADDR_W'(issued)));
            end
            if (instr_valid && instr_ready) begin
                chk("rnd_pc", 32'(instr_pc), 32'(exp_pc));
                chk("rnd_instr", 32'(instr), 32'(exp_pc));
                exp_pc = exp_pc + 12'd1;
                popped++;
            end
            if (imem_req) issued++;
            tick();
        end
        chk("rnd_progress", 32'(popped > 200), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
